mem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between instruction fetch (I port) and the load/store stage (D port).

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (I) and load/store (D) ports
// Optional starvation guard for the I port is enabled with `define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner_i;
    logic        owner_d;
    logic        store_l;
    logic [1:0]  wait_cnt;
    logic        wait_done;
    logic        any_req;
    logic        grant;
    logic        grant_d;
    logic        resp_load;

    logic        mem_en_next;
    logic        mem_we_next;
    logic [31:0] mem_addr_next;
    logic [31:0] mem_wdata_next;
    logic        i_valid_next;
    logic        d_valid_next;
    logic [31:0] i_rdata_next;
    logic [31:0] d_rdata_next;

    // Parameter values outside the legal ranges produce this marker block.
    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_illegal_params
    end

    assign any_req   = i_req | d_req;
    assign grant     = (state == IDLE) && any_req;
    assign wait_done = (wait_cnt == 2'(MEM_LAT - 1));
    assign resp_load = (state == WAIT) && wait_done;
    assign arb_busy  = (state != IDLE);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic       starve_hit;

    // Hand one grant to I once D has won STARVE_LIMIT contested arbitrations in a row.
    assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT)) && i_req && d_req;
    assign grant_d    = d_req && !starve_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (grant) begin
            if (!grant_d || !i_req) begin
                starve_cnt <= 4'd0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = store_l ? RESP : WAIT;
            WAIT:    if (wait_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en_next    = grant;
        mem_we_next    = grant && grant_d && d_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        if (grant) begin
            mem_addr_next = grant_d ? d_addr : i_addr;
            if (grant_d) begin
                mem_wdata_next = d_wdata;
            end
        end
        i_valid_next = resp_load && owner_i;
        d_valid_next = (resp_load && owner_d) || ((state == ISSUE) && store_l);
        i_rdata_next = (resp_load && owner_i) ? mem_rdata : i_rdata;
        d_rdata_next = (resp_load && owner_d) ? mem_rdata : d_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            owner_i   <= 1'b0;
            owner_d   <= 1'b0;
            store_l   <= 1'b0;
            wait_cnt  <= 2'd0;
        end else begin
            mem_en    <= mem_en_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            i_valid   <= i_valid_next;
            d_valid   <= d_valid_next;
            i_rdata   <= i_rdata_next;
            d_rdata   <= d_rdata_next;
            if (grant) begin
                owner_i <= !grant_d;
                owner_d <= grant_d;
                store_l <= grant_d && d_we;
            end
            if (state == ISSUE) begin
                wait_cnt <= 2'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Works with or without `define ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int MEM_LAT      = 3;
    localparam int STARVE_LIMIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        arb_busy;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro with MEM_LAT-cycle read latency.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_en) rd_pipe[0] <= mem[mem_addr[9:2]];
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        int          exp_cyc;
        logic [31:0] exp_data;
    } sb_t;

    sb_t         sbq[$];
    sb_t         ent;
    bit          sb_en = 1'b1;
    logic [31:0] mdl_i = 32'd0;
    logic [31:0] mdl_d = 32'd0;

    always @(negedge clk) begin
        if (sb_en && !rst) begin
            check("we_without_en", 32'(mem_we & ~mem_en), 32'd0);
            if (i_valid || d_valid) begin
                check("dual_valid", 32'(i_valid & d_valid), 32'd0);
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got i_valid=%0b d_valid=%0b, want none (cycle %0d)",
                             i_valid, d_valid, cyc);
                end else begin
                    ent = sbq.pop_front();
                    check("valid_port", 32'(d_valid), 32'(ent.is_d));
                    check("valid_cycle", 32'(cyc), 32'(ent.exp_cyc));
                    if (ent.is_d) begin
                        if (!ent.we) mdl_d = ent.exp_data;
                        check("d_rdata", d_rdata, mdl_d);
                        check("i_rdata_hold", i_rdata, mdl_i);
                    end else begin
                        mdl_i = ent.exp_data;
                        check("i_rdata", i_rdata, mdl_i);
                        check("d_rdata_hold", d_rdata, mdl_d);
                    end
                end
            end
        end
    end

    task automatic wait_valid(input bit is_d);
        int k;
        k = 0;
        while (((is_d ? d_valid : i_valid) !== 1'b1) && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (k >= 40) begin
            fails++;
            $display("FAIL valid_timeout: got no %s_valid, want a pulse within 40 cycles", is_d ? "d" : "i");
        end
        @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge in an IDLE cycle; returns in the IDLE cycle after valid.
    task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        int t;
        t = cyc;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        sbq.push_back('{is_d, we, t + 2 + (we ? 0 : MEM_LAT), exp});
        @(negedge clk);
        check("idle_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("issue_mem_en", 32'(mem_en), 32'd1);
        check("issue_mem_we", 32'(mem_we), 32'(is_d & we));
        check("issue_mem_addr", mem_addr, addr);
        check("issue_busy", 32'(arb_busy), 32'd1);
        if (is_d && we) check("issue_mem_wdata", mem_wdata, wdata);
        wait_valid(is_d);
        if (is_d) d_req = 1'b0;
        else i_req = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t  vecs[10];
    string order;
    string want;
    int    n;
    int    k;
    int    t0;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h014, 32'h0, 32'h00A00113};
        vecs[3] = '{1'b1, 1'b1, 32'h020, 32'h12345678, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h020, 32'h0, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h010, 32'h0, 32'h00500093};
        vecs[6] = '{1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF};
        vecs[7] = '{1'b1, 1'b1, 32'h3FC, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h3FC, 32'h0, 32'hFFFFFFFF};
        vecs[9] = '{1'b0, 1'b0, 32'h000, 32'h0, 32'hCAFEF00D};

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0] = 32'hCAFEF00D;
        mem[4] = 32'h00500093;
        mem[5] = 32'h00A00113;

        // Reset held for two cycles with both requests high.
        rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h55AA55AA;
        repeat (2) begin
            @(negedge clk);
            check("reset_ctrl", {28'd0, mem_en, mem_we, i_valid, d_valid}, 32'd0);
            check("reset_busy", 32'(arb_busy), 32'd0);
            check("reset_bus", mem_addr | mem_wdata | i_rdata | d_rdata, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093);

        for (int i = 0; i < 10; i++)
            txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Contention: D wins, I re-arbitrated at the next IDLE.
        t0 = cyc;
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        sbq.push_back('{1'b1, 1'b0, t0 + 2 + MEM_LAT, 32'hDEADBEEF});
        sbq.push_back('{1'b0, 1'b0, t0 + 5 + 2 * MEM_LAT, 32'h00A00113});
        wait_valid(1'b1);
        d_req = 1'b0;
        wait_valid(1'b0);
        i_req = 1'b0;
        check("contention_drained", 32'(sbq.size()), 32'd0);

        // Starvation: both requests held continuously.
        sb_en = 1'b0;
        order = "";
`ifdef ARB_STARVE_GUARD_EN
        want = "DDIDDI";
`else
        want = "DDDDDDDD";
`endif
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        n = 0;
        k = 0;
        while (n < want.len() && k < 200) begin
            @(negedge clk);
            k++;
            if (d_valid) begin order = {order, "D"}; n++; end
            if (i_valid) begin order = {order, "I"}; n++; end
        end
        @(posedge clk);
        #1;
        i_req = 1'b0; d_req = 1'b0;
        tests++;
        if (order != want) begin
            fails++;
            $display("FAIL starve_order: got %s, want %s", order, want);
        end
        repeat (MEM_LAT + 4) @(negedge clk);
        check("starve_idle", 32'(arb_busy), 32'd0);
        check("starve_d_rdata", d_rdata, 32'h12345678);
        mdl_d = 32'h12345678;
`ifdef ARB_STARVE_GUARD_EN
        mdl_i = 32'h00500093;
`endif
        check("starve_i_rdata", i_rdata, mdl_i);
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // Reset pulsed during the second WAIT cycle of a fetch.
        i_req = 1'b1; i_addr = 32'h14;
        @(negedge clk);
        @(negedge clk);
        check("rw_issue", 32'(mem_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rw_wait_busy", 32'(arb_busy), 32'd1);
        rst = 1'b1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw_idle_busy", 32'(arb_busy), 32'd0);
        check("rw_ctrl", {28'd0, mem_en, mem_we, i_valid, d_valid}, 32'd0);
        check("rw_rdata", i_rdata | d_rdata, 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("rw_no_valid", 32'(i_valid | d_valid), 32'd0);
        end
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
